// File: rtl/case_vec_pkg.sv
// Shared types and the hold-model reference for the case-decoder vector driver.
package case_vec_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

    localparam int DEF_W          = 3;
    localparam int DEF_NUM_LABELS = 3;
    localparam int MAX_W          = 8;

    // A key that hits a label becomes the new result; any other key keeps the old one.
    function automatic logic [MAX_W-1:0] exp_next(input logic [MAX_W-1:0] key,
                                                  input logic [MAX_W-1:0] exp_prev,
                                                  input int               num_labels);
        return (int'(key) < num_labels) ? key : exp_prev;
    endfunction

endpackage

// File: rtl/case_hold_model.sv
// Registered expected-result model of the hold decoder, with clear and load.
module case_hold_model
    import case_vec_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_next,
    output logic [W-1:0] o_exp
);

    logic [W-1:0] r_exp;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_exp <= '0;
        end else if (i_load) begin
            r_exp <= i_next;
        end
    end

    assign o_exp = r_exp;

endmodule

// File: rtl/case_vec_driver.sv
// Walks every operand pair into a masked-label case decoder and checks its result
// against a hold model, keeping a sticky error, first failing index and error count.
module case_vec_driver
    import case_vec_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int NUM_LABELS = DEF_NUM_LABELS,
    parameter int SETTLE     = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   result,
    output logic [W-1:0]   val1,
    output logic [W-1:0]   val2,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [2*W-1:0] fail_idx,
    output logic [2*W:0]   err_count
);

    localparam int IW = 2 * W;
    localparam int EW = 2 * W + 1;
    localparam int CW = $clog2(SETTLE + 1) + 1;
    localparam logic [IW-1:0] LAST_IDX  = '1;
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE);

    state_t        r_state;
    state_t        w_stateNext;
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_cnt;
    logic          r_error;
    logic [IW-1:0] r_failIdx;
    logic [EW-1:0] r_errCount;

    logic          w_accept;
    logic          w_checking;
    logic          w_mismatch;
    logic [W-1:0]  w_key;
    logic [W-1:0]  w_exp;
    logic [W-1:0]  w_expNext;

    assign val1       = r_idx[IW-1:W];
    assign val2       = r_idx[W-1:0];
    assign w_key      = val1 & val2;
    assign w_accept   = (r_state == IDLE) && start;
    assign w_checking = (r_state == CHECK);
    assign w_expNext  = W'(exp_next(MAX_W'(w_key), MAX_W'(w_exp), NUM_LABELS));
    assign w_mismatch = w_checking && (result != w_expNext);

    case_hold_model #(.W(W)) u_holdModel (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clear (w_accept),
        .i_load  (w_checking),
        .i_next  (w_expNext),
        .o_exp   (w_exp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (r_cnt <= CW'(1)) begin
                    w_stateNext = CHECK;
                end
            end
            CHECK: begin
                busy        = 1'b1;
                w_stateNext = (r_idx == LAST_IDX) ? DONE : WAIT;
            end
            DONE: begin
                done        = 1'b1;
                w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Vector index, settle counter and error bookkeeping; results hold after DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_cnt      <= '0;
            r_error    <= 1'b0;
            r_failIdx  <= '0;
            r_errCount <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx      <= '0;
                        r_cnt      <= SETTLE_LD;
                        r_error    <= 1'b0;
                        r_failIdx  <= '0;
                        r_errCount <= '0;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - CW'(1);
                end
                CHECK: begin
                    if (w_mismatch) begin
                        r_error <= 1'b1;
                        if (r_errCount != '1) begin
                            r_errCount <= r_errCount + EW'(1);
                        end
                        if (!r_error) begin
                            r_failIdx <= r_idx;
                        end
                    end
                    if (r_idx != LAST_IDX) begin
                        r_idx <= r_idx + IW'(1);
                        r_cnt <= SETTLE_LD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign error     = r_error;
    assign fail_idx  = r_failIdx;
    assign err_count = r_errCount;

endmodule

// File: tb/tb_case_vec_driver.sv
// Directed bench: two drivers (SETTLE=1 and SETTLE=3) each paired with a bench-side
// decoder whose behaviour is selected per run to provoke known pass/fail outcomes.
module tb_case_vec_driver;

    import case_vec_pkg::*;

    localparam int W = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           startA = 1'b0;
    logic           startB = 1'b0;
    logic [W-1:0]   resultA, resultB;
    logic [W-1:0]   v1A, v2A, v1B, v2B;
    logic           busyA, doneA, errorA, busyB, doneB, errorB;
    logic [2*W-1:0] failIdxA, failIdxB;
    logic [2*W:0]   errCountA, errCountB;
    logic [W-1:0]   keyA, keyB, lastA, regB;
    logic [1:0]     decMode = 2'd0;
    int             checks = 0;
    int             errors = 0;
    int             cyc;

    always #5 clk = ~clk;

    case_vec_driver #(.W(W), .NUM_LABELS(3), .SETTLE(1)) dutA (
        .clk(clk), .rst(rst), .start(startA), .result(resultA),
        .val1(v1A), .val2(v2A), .busy(busyA), .done(doneA),
        .error(errorA), .fail_idx(failIdxA), .err_count(errCountA)
    );

    case_vec_driver #(.W(W), .NUM_LABELS(3), .SETTLE(3)) dutB (
        .clk(clk), .rst(rst), .start(startB), .result(resultB),
        .val1(v1B), .val2(v2B), .busy(busyB), .done(doneB),
        .error(errorB), .fail_idx(failIdxB), .err_count(errCountB)
    );

    // Decoder A: 0 = correct hold, 1 = zero on no-match, 2 = stuck at zero.
    assign keyA = v1A & v2A;
    always_comb begin
        resultA = '0;
        case (decMode)
            2'd0:    resultA = (keyA < 3'd3) ? keyA : lastA;
            2'd1:    resultA = (keyA < 3'd3) ? keyA : 3'd0;
            default: resultA = '0;
        endcase
    end
    always @(posedge clk) lastA <= (rst || startA) ? 3'd0 : resultA;

    // Decoder B: correct hold behaviour with a one-cycle registered output.
    assign keyB = v1B & v2B;
    always @(posedge clk) regB <= (rst || startB) ? 3'd0 : ((keyB < 3'd3) ? keyB : regB);
    assign resultB = regB;

    function automatic int refErrCount(input int mode);
        int e, cnt, k, r;
        e   = 0;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            k = (i >> 3) & (i & 7);
            if (k < 3) e = k;
            if (mode == 1) r = (k < 3) ? k : 0;
            else           r = 0;
            if (r != e) cnt++;
        end
        return cnt;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic sA, input logic sB, input logic r);
        @(negedge clk);
        startA = sA;
        startB = sB;
        rst    = r;
        @(posedge clk);
        #1;
        startA = 1'b0;
        startB = 1'b0;
        rst    = 1'b0;
    endtask

    // Counts cycles after the start edge until done; optionally re-pokes start mid-run.
    task automatic waitDone(input bit sel, input int pokeAt, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            startA = (pokeAt > 0) && (n == pokeAt || n == pokeAt + 1);
        end while (!(sel ? doneB : doneA) && n < 400);
        startA = 1'b0;
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rst_val1", v1A, 0);
        checkOutput("rst_val2", v2A, 0);
        checkOutput("rst_busy", busyA, 0);
        checkOutput("rst_done", doneA, 0);
        checkOutput("rst_error", errorA, 0);
        checkOutput("rst_failIdx", failIdxA, 0);
        checkOutput("rst_errCount", errCountA, 0);

        $display("[TB] run A: correct hold decoder");
        decMode = 2'd0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("A_busyRise", busyA, 1);
        checkOutput("A_val1Start", v1A, 0);
        checkOutput("A_val2Start", v2A, 0);
        waitDone(1'b0, 0, cyc);
        checkOutput("A_doneCycle", cyc, 129);
        checkOutput("A_busyAtDone", busyA, 0);
        checkOutput("A_error", errorA, 0);
        checkOutput("A_errCount", errCountA, 0);
        checkOutput("A_val1Hold", v1A, 7);
        checkOutput("A_val2Hold", v2A, 7);
        @(negedge clk);
        checkOutput("A_donePulse", doneA, 0);

        $display("[TB] run B: decoder without hold");
        decMode = 2'd1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitDone(1'b0, 0, cyc);
        checkOutput("B_doneCycle", cyc, 129);
        checkOutput("B_error", errorA, 1);
        checkOutput("B_failIdx", failIdxA, 27);
        checkOutput("B_errCount", errCountA, refErrCount(1));

        $display("[TB] run C: decoder stuck at zero");
        decMode = 2'd2;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("C_errorCleared", errorA, 0);
        checkOutput("C_failIdxCleared", failIdxA, 0);
        checkOutput("C_errCountCleared", errCountA, 0);
        waitDone(1'b0, 0, cyc);
        checkOutput("C_error", errorA, 1);
        checkOutput("C_failIdx", failIdxA, 9);
        checkOutput("C_errCount", errCountA, refErrCount(2));

        $display("[TB] run D: start re-asserted mid-run");
        decMode = 2'd0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitDone(1'b0, 10, cyc);
        checkOutput("D_doneCycle", cyc, 129);
        checkOutput("D_error", errorA, 0);
        checkOutput("D_errCount", errCountA, 0);
        @(negedge clk);
        checkOutput("D_singleDone", doneA, 0);

        $display("[TB] run E: reset mid-run");
        decMode = 2'd2;
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (39) @(negedge clk);
        checkOutput("E_errorBeforeRst", errorA, 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("E_val1", v1A, 0);
        checkOutput("E_val2", v2A, 0);
        checkOutput("E_busy", busyA, 0);
        checkOutput("E_error", errorA, 0);
        checkOutput("E_failIdx", failIdxA, 0);
        checkOutput("E_errCount", errCountA, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("E_idleNoDone", {busyA, doneA}, 0);
        end
        decMode = 2'd0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitDone(1'b0, 0, cyc);
        checkOutput("E_rerunDoneCycle", cyc, 129);
        checkOutput("E_rerunError", errorA, 0);

        $display("[TB] run F: SETTLE=3 with registered decoder");
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("F_busyRise", busyB, 1);
        waitDone(1'b1, 0, cyc);
        checkOutput("F_doneCycle", cyc, 257);
        checkOutput("F_error", errorB, 0);
        checkOutput("F_errCount", errCountB, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
